// File: rtl/display_sequencer.sv
// Display source sequencer: debounced step key, optional auto-scroll and a timed
// hold that forces a freshly produced ALU result onto the display mux.
module display_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DWELL_CYCLES    = 50000000,
   parameter int HOLD_CYCLES     = 100000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       step_key_n,
   input  logic       auto_en,
   input  logic       result_valid,
   output logic [1:0] display_select,
   output logic       hold_active,
   output logic       sel_changed
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int DW_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
   localparam int HD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
   localparam logic [HD_W-1:0] HOLD_LAST  = HD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      SHOW_A   = 2'b00,
      SHOW_B   = 2'b01,
      SHOW_RES = 2'b10,
      HOLD_RES = 2'b11
   } state_t;

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            stable_q, stable_d;
   logic            step_q, step_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   state_t          state_q, state_d;
   logic [DW_W-1:0] dwell_q, dwell_d;
   logic [HD_W-1:0] hold_q, hold_d;
   logic [1:0]      sel_q, sel_d;
   logic            hold_act_q, hold_act_d;
   logic            changed_q, changed_d;

   // Leaving HOLD_RES by a step always returns to the first source.
   function automatic state_t next_src(input state_t s);
      case (s)
         SHOW_A:  return SHOW_B;
         SHOW_B:  return SHOW_RES;
         default: return SHOW_A;
      endcase
   endfunction

   function automatic logic [1:0] sel_of(input state_t s);
      case (s)
         SHOW_A:  return 2'b00;
         SHOW_B:  return 2'b01;
         default: return 2'b10;
      endcase
   endfunction

   always_comb begin
      sync1_d  = step_key_n;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      db_cnt_d = '0;
      if (sync2_q != stable_q) begin
         if (db_cnt_q == DB_LAST) begin
            stable_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
      // Press only: stable level falling edge.
      step_d = stable_q & ~stable_d;

      state_d = state_q;
      dwell_d = '0;
      hold_d  = hold_q;
      if (result_valid) begin
         state_d = HOLD_RES;
         hold_d  = '0;
      end else if (step_q) begin
         state_d = next_src(state_q);
      end else if (state_q == HOLD_RES) begin
         if (hold_q == HOLD_LAST) begin
            state_d = SHOW_RES;
            hold_d  = '0;
         end else begin
            hold_d = hold_q + 1'b1;
         end
      end else if (auto_en) begin
         if (dwell_q == DWELL_LAST) begin
            state_d = next_src(state_q);
         end else begin
            dwell_d = dwell_q + 1'b1;
         end
      end

      sel_d      = sel_of(state_d);
      hold_act_d = (state_d == HOLD_RES);
      changed_d  = (sel_d != sel_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         stable_q   <= 1'b1;
         step_q     <= 1'b0;
         db_cnt_q   <= '0;
         state_q    <= SHOW_A;
         dwell_q    <= '0;
         hold_q     <= '0;
         sel_q      <= 2'b00;
         hold_act_q <= 1'b0;
         changed_q  <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         stable_q   <= stable_d;
         step_q     <= step_d;
         db_cnt_q   <= db_cnt_d;
         state_q    <= state_d;
         dwell_q    <= dwell_d;
         hold_q     <= hold_d;
         sel_q      <= sel_d;
         hold_act_q <= hold_act_d;
         changed_q  <= changed_d;
      end
   end

   assign display_select = sel_q;
   assign hold_active    = hold_act_q;
   assign sel_changed    = changed_q;

endmodule
